// File: rtl/itch_ingress_pkg.sv
// Shared types and helpers for the ITCH ingress byte serializer.
package itch_ingress_pkg;

    localparam int unsigned BYTE_ORDER_LSB_FIRST = 0;
    localparam int unsigned BYTE_ORDER_MSB_FIRST = 1;

    // Serializer state tracks what the output register currently holds.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EMIT      = 2'd1,
        ST_LAST_LANE = 2'd2
    } ser_state_e;

    // First kept lane at or beyond cur in walk order; bit 7 set when none remain.
    function automatic logic [7:0] next_kept_lane(input logic [63:0] keep,
                                                  input logic [6:0]  cur,
                                                  input logic        order);
        logic [7:0] res;
        res = 8'h80;
        if (!order) begin
            for (int i = 63; i >= 0; i--) begin
                if (keep[i] && (7'(i) >= cur)) res = {1'b0, 7'(i)};
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (keep[i] && (7'(i) <= cur)) res = {1'b0, 7'(i)};
            end
        end
        return res;
    endfunction

    // Final kept lane of a beat in walk order.
    function automatic logic [6:0] last_kept_lane(input logic [63:0] keep,
                                                  input logic        order);
        logic [6:0] res;
        res = 7'd0;
        if (!order) begin
            for (int i = 0; i < 64; i++) begin
                if (keep[i]) res = 7'(i);
            end
        end else begin
            for (int i = 63; i >= 0; i--) begin
                if (keep[i]) res = 7'(i);
            end
        end
        return res;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0]   val,
                                            input int unsigned   width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val == max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/itch_beat_fifo.sv
// Generic synchronous FIFO holding whole AXIS beats.
module itch_beat_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally for power-of-2 depth; level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (pop && !push) level <= level - LVL_W'(1);
        end
    end

endmodule

// File: rtl/itch_axis_byte_serializer.sv
// AXI-Stream slave to one-byte-per-cycle ITCH parser feed with TKEEP handling.
module itch_axis_byte_serializer
    import itch_ingress_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH           = 4,
    parameter int unsigned BYTE_ORDER           = 0,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic [7:0]                          byte_out,
    output logic                                byte_valid,
    input  logic                                byte_ready,
    output logic                                byte_last,
    input  logic                                clear_counters,
    output logic [CNT_WIDTH-1:0]                byte_count,
    output logic [CNT_WIDTH-1:0]                frame_count,
    output logic [CNT_WIDTH-1:0]                null_beat_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);
    localparam int unsigned NB     = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned BEAT_W = NB * 9 + 1;
    localparam logic        ORDER  = (BYTE_ORDER == BYTE_ORDER_MSB_FIRST);
    localparam logic [6:0]  START_LANE = ORDER ? 7'(NB - 1) : 7'd0;

    logic                              arm_q;
    logic                              run_q;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic                              accept;
    logic                              push;
    logic                              null_beat;
    logic [BEAT_W-1:0]                 head_beat;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   head_data;
    logic [NB-1:0]                     head_keep;
    logic                              head_last;
    logic [7:0]                        cur_res;
    logic [6:0]                        cur_lane;
    logic [6:0]                        final_lane;
    logic [6:0]                        lane_q;
    logic [6:0]                        lane_d;
    logic                              final_c;
    logic                              load_c;
    logic                              pop_c;
    logic                              hs_c;
    logic [7:0]                        byte_sel;
    ser_state_e                        state_q;
    ser_state_e                        state_d;

    assign S_AXIS_TREADY = run_q & ~fifo_full;
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
    assign push          = accept & (|S_AXIS_TKEEP);
    assign null_beat     = accept & ~(|S_AXIS_TKEEP);

    assign {head_data, head_keep, head_last} = head_beat;

    itch_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (S_AXIS_ACLK),
        .rst_n   (S_AXIS_ARESETN),
        .push    (push),
        .wr_data ({S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST}),
        .pop     (pop_c),
        .rd_data (head_beat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Run flag opens TREADY on the second edge after reset release.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            arm_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            arm_q <= 1'b1;
            run_q <= arm_q;
        end
    end

    // Lane search over the head beat: current kept lane and the beat's final one.
    always_comb begin
        cur_res    = next_kept_lane(64'(head_keep), lane_q, ORDER);
        cur_lane   = cur_res[6:0];
        final_lane = last_kept_lane(64'(head_keep), ORDER);
        final_c    = (cur_lane == final_lane);
        byte_sel   = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (cur_lane == 7'(i)) byte_sel = head_data[i*8 +: 8];
        end
    end

    // State register.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) state_q <= ST_IDLE;
        else                 state_q <= state_d;
    end

    // Next state follows what the output register will hold after this edge.
    always_comb begin
        state_d = state_q;
        if (load_c)    state_d = final_c ? ST_LAST_LANE : ST_EMIT;
        else if (hs_c) state_d = ST_IDLE;
    end

    // Control outputs: load when the output slot frees up, pop on the final lane.
    always_comb begin
        hs_c   = byte_valid & byte_ready;
        load_c = (~byte_valid | byte_ready) & ~fifo_empty & ~cur_res[7];
        pop_c  = load_c & final_c;
        lane_d = lane_q;
        if (load_c) begin
            if (final_c)    lane_d = START_LANE;
            else if (ORDER) lane_d = cur_lane - 7'd1;
            else            lane_d = cur_lane + 7'd1;
        end
    end

    // Output register and lane pointer; contents hold until a handshake frees them.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            byte_valid <= 1'b0;
            byte_out   <= 8'h00;
            byte_last  <= 1'b0;
            lane_q     <= START_LANE;
        end else begin
            byte_valid <= (state_d != ST_IDLE);
            lane_q     <= lane_d;
            if (load_c) begin
                byte_out  <= byte_sel;
                byte_last <= final_c & head_last;
            end
        end
    end

    // Saturating status counters; clear wins over a same-cycle increment.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            byte_count      <= '0;
            frame_count     <= '0;
            null_beat_count <= '0;
        end else if (clear_counters) begin
            byte_count      <= '0;
            frame_count     <= '0;
            null_beat_count <= '0;
        end else begin
            if (hs_c)
                byte_count <= CNT_WIDTH'(sat_inc(64'(byte_count), CNT_WIDTH));
            if (hs_c && byte_last)
                frame_count <= CNT_WIDTH'(sat_inc(64'(frame_count), CNT_WIDTH));
            if (null_beat)
                null_beat_count <= CNT_WIDTH'(sat_inc(64'(null_beat_count), CNT_WIDTH));
        end
    end

endmodule

// File: tb/tb_itch_axis_byte_serializer.sv
// Scoreboard bench: two 32-bit instances (LSB/MSB first) and one 64-bit instance.
module tb_itch_axis_byte_serializer;
    timeunit 1ns;
    timeprecision 1ps;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br;
    logic        clr;

    logic [31:0] t32_data;
    logic [3:0]  t32_keep;
    logic        t32_last;
    logic        t32_valid;
    logic [63:0] t64_data;
    logic [7:0]  t64_keep;
    logic        t64_last;
    logic        t64_valid;

    logic        a_tready, a_valid, a_last;
    logic [7:0]  a_byte;
    logic [31:0] a_bc, a_fc, a_nc;
    logic [2:0]  a_lvl;
    logic        b_tready, b_valid, b_last;
    logic [7:0]  b_byte;
    logic [31:0] b_bc, b_fc, b_nc;
    logic [2:0]  b_lvl;
    logic        c_tready, c_valid, c_last;
    logic [7:0]  c_byte;
    logic [31:0] c_bc, c_fc, c_nc;
    logic [2:0]  c_lvl;

    int errors = 0;
    int checks = 0;
    int gaps   = 0;
    bit rand_ready = 1'b0;

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] q_c[$];

    logic       prev_av, prev_bv, prev_cv, prev_br;
    logic [8:0] prev_a, prev_b, prev_c;

    int exp32_bytes = 0, exp32_frames = 0, exp32_null = 0;
    int exp64_bytes = 0, exp64_frames = 0, exp64_null = 0;

    always #5 clk = ~clk;

    itch_axis_byte_serializer #(
        .C_S_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(4), .BYTE_ORDER(0), .CNT_WIDTH(32)
    ) u_a (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TREADY(a_tready),
        .S_AXIS_TDATA(t32_data), .S_AXIS_TKEEP(t32_keep), .S_AXIS_TLAST(t32_last),
        .S_AXIS_TVALID(t32_valid), .byte_out(a_byte), .byte_valid(a_valid),
        .byte_ready(br), .byte_last(a_last), .clear_counters(clr),
        .byte_count(a_bc), .frame_count(a_fc), .null_beat_count(a_nc), .fifo_level(a_lvl)
    );

    itch_axis_byte_serializer #(
        .C_S_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(4), .BYTE_ORDER(1), .CNT_WIDTH(32)
    ) u_b (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TREADY(b_tready),
        .S_AXIS_TDATA(t32_data), .S_AXIS_TKEEP(t32_keep), .S_AXIS_TLAST(t32_last),
        .S_AXIS_TVALID(t32_valid), .byte_out(b_byte), .byte_valid(b_valid),
        .byte_ready(br), .byte_last(b_last), .clear_counters(clr),
        .byte_count(b_bc), .frame_count(b_fc), .null_beat_count(b_nc), .fifo_level(b_lvl)
    );

    itch_axis_byte_serializer #(
        .C_S_AXIS_TDATA_WIDTH(64), .FIFO_DEPTH(4), .BYTE_ORDER(0), .CNT_WIDTH(32)
    ) u_c (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TREADY(c_tready),
        .S_AXIS_TDATA(t64_data), .S_AXIS_TKEEP(t64_keep), .S_AXIS_TLAST(t64_last),
        .S_AXIS_TVALID(t64_valid), .byte_out(c_byte), .byte_valid(c_valid),
        .byte_ready(br), .byte_last(c_last), .clear_counters(clr),
        .byte_count(c_bc), .frame_count(c_fc), .null_beat_count(c_nc), .fifo_level(c_lvl)
    );

    // One clock: check outputs at the falling edge, then move past the rising edge.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        if (rst_n) begin
            if (prev_av && !prev_br) begin
                checks++;
                if (a_valid !== 1'b1 || {a_byte, a_last} !== prev_a) begin
                    errors++;
                    $display("FAIL hold_a: valid=%b byte/last=%h, required valid=1 byte/last=%h", a_valid, {a_byte, a_last}, prev_a);
                end
            end
            if (prev_bv && !prev_br) begin
                checks++;
                if (b_valid !== 1'b1 || {b_byte, b_last} !== prev_b) begin
                    errors++;
                    $display("FAIL hold_b: valid=%b byte/last=%h, required valid=1 byte/last=%h", b_valid, {b_byte, b_last}, prev_b);
                end
            end
            if (prev_cv && !prev_br) begin
                checks++;
                if (c_valid !== 1'b1 || {c_byte, c_last} !== prev_c) begin
                    errors++;
                    $display("FAIL hold_c: valid=%b byte/last=%h, required valid=1 byte/last=%h", c_valid, {c_byte, c_last}, prev_c);
                end
            end
            if (a_valid && br) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte_a: got byte=%h last=%b, required no byte", a_byte, a_last);
                end else begin
                    e = q_a.pop_front();
                    if ({a_byte, a_last} !== e) begin
                        errors++;
                        $display("FAIL stream_a: got byte=%h last=%b, required byte=%h last=%b", a_byte, a_last, e[8:1], e[0]);
                    end
                end
            end
            if (b_valid && br) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte_b: got byte=%h last=%b, required no byte", b_byte, b_last);
                end else begin
                    e = q_b.pop_front();
                    if ({b_byte, b_last} !== e) begin
                        errors++;
                        $display("FAIL stream_b: got byte=%h last=%b, required byte=%h last=%b", b_byte, b_last, e[8:1], e[0]);
                    end
                end
            end
            if (c_valid && br) begin
                checks++;
                if (q_c.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte_c: got byte=%h last=%b, required no byte", c_byte, c_last);
                end else begin
                    e = q_c.pop_front();
                    if ({c_byte, c_last} !== e) begin
                        errors++;
                        $display("FAIL stream_c: got byte=%h last=%b, required byte=%h last=%b", c_byte, c_last, e[8:1], e[0]);
                    end
                end
            end
            if (br && q_a.size() != 0 && !a_valid) gaps++;
        end
        prev_av = a_valid; prev_bv = b_valid; prev_cv = c_valid; prev_br = br;
        prev_a = {a_byte, a_last}; prev_b = {b_byte, b_last}; prev_c = {c_byte, c_last};
        @(posedge clk);
        #1;
        if (rand_ready) br = ($urandom_range(0, 1) == 1);
    endtask

    // Expected kept-byte streams for the LSB-first and MSB-first 32-bit instances.
    task automatic push32(input logic [31:0] d, input logic [3:0] k, input logic l);
        int hi, lo;
        hi = 0; lo = 3;
        if (k == 4'h0) begin
            exp32_null++;
        end else begin
            for (int i = 0; i < 4; i++) if (k[i]) hi = i;
            for (int i = 3; i >= 0; i--) if (k[i]) lo = i;
            for (int i = 0; i < 4; i++)
                if (k[i]) begin q_a.push_back({d[i*8 +: 8], l && (i == hi)}); exp32_bytes++; end
            for (int i = 3; i >= 0; i--)
                if (k[i]) q_b.push_back({d[i*8 +: 8], l && (i == lo)});
            if (l) exp32_frames++;
        end
    endtask

    task automatic push64(input logic [63:0] d, input logic [7:0] k, input logic l);
        int hi;
        hi = 0;
        if (k == 8'h00) begin
            exp64_null++;
        end else begin
            for (int i = 0; i < 8; i++) if (k[i]) hi = i;
            for (int i = 0; i < 8; i++)
                if (k[i]) begin q_c.push_back({d[i*8 +: 8], l && (i == hi)}); exp64_bytes++; end
            if (l) exp64_frames++;
        end
    endtask

    // Present a beat; acc reports whether it was taken within budget cycles.
    task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic l,
                          input int budget, output bit acc);
        int n;
        t32_data = d; t32_keep = k; t32_last = l; t32_valid = 1'b1;
        n = 0;
        while (!a_tready && n < budget) begin step(); n++; end
        acc = a_tready;
        if (acc) begin
            push32(d, k, l);
            step();
            t32_valid = 1'b0;
        end
    endtask

    task automatic send64(input logic [63:0] d, input logic [7:0] k, input logic l,
                          input int budget, output bit acc);
        int n;
        t64_data = d; t64_keep = k; t64_last = l; t64_valid = 1'b1;
        n = 0;
        while (!c_tready && n < budget) begin step(); n++; end
        acc = c_tready;
        if (acc) begin
            push64(d, k, l);
            step();
            t64_valid = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0 ||
                a_valid || b_valid || c_valid) && n < budget) begin
            step(); n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d c=%0d after %0d cycles, required 0", q_a.size(), q_b.size(), q_c.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; br = 1'b0; clr = 1'b0;
        t32_valid = 1'b0; t32_data = '0; t32_keep = '0; t32_last = 1'b0;
        t64_valid = 1'b0; t64_data = '0; t64_keep = '0; t64_last = 1'b0;
        prev_av = 0; prev_bv = 0; prev_cv = 0; prev_br = 0;
        prev_a = '0; prev_b = '0; prev_c = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_tready, a_valid, a_last, a_byte, a_bc, a_fc, a_nc, a_lvl} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a: tready=%b valid=%b byte=%h cnt=%0d/%0d/%0d lvl=%0d, required all 0", a_tready, a_valid, a_byte, a_bc, a_fc, a_nc, a_lvl);
        end
        checks++;
        if ({c_tready, c_valid, c_last, c_byte, c_bc, c_fc, c_nc, c_lvl} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_c: tready=%b valid=%b byte=%h lvl=%0d, required all 0", c_tready, c_valid, c_byte, c_lvl);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (a_tready !== 1'b0) begin
            errors++;
            $display("FAIL tready_edge1: got %b, required 0", a_tready);
        end
        step();
        checks++;
        if (a_tready !== 1'b1 || c_tready !== 1'b1) begin
            errors++;
            $display("FAIL tready_edge2: got a=%b c=%b, required 1", a_tready, c_tready);
        end
    endtask

    task automatic test_full_keep();
        bit acc;
        br = 1'b1;
        send32(32'h44332211, 4'hF, 1'b1, 4, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL accept_full: got 0, required 1"); end
        checks++;
        if (a_valid !== 1'b0) begin errors++; $display("FAIL latency_pre: valid=%b, required 0", a_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (a_valid !== (i < 4)) begin
                errors++;
                $display("FAIL back_to_back_valid[%0d]: valid=%b, required %b", i, a_valid, (i < 4));
            end
        end
        drain(20);
        checks++;
        if (a_bc !== 32'(exp32_bytes) || a_fc !== 32'(exp32_frames) || b_bc !== 32'(exp32_bytes) || b_fc !== 32'(exp32_frames)) begin
            errors++;
            $display("FAIL counts_full: a=%0d/%0d b=%0d/%0d, required %0d/%0d", a_bc, a_fc, b_bc, b_fc, exp32_bytes, exp32_frames);
        end
    endtask

    task automatic test_sparse();
        bit acc;
        br = 1'b1;
        send32(32'hDDCCBBAA, 4'b1010, 1'b1, 4, acc);
        send32(32'h12345678, 4'b0000, 1'b1, 4, acc);
        drain(20);
        checks++;
        if (a_nc !== 32'(exp32_null) || b_nc !== 32'(exp32_null) || a_fc !== 32'(exp32_frames) || a_bc !== 32'(exp32_bytes)) begin
            errors++;
            $display("FAIL counts_sparse: null=%0d/%0d frames=%0d bytes=%0d, required null=%0d frames=%0d bytes=%0d", a_nc, b_nc, a_fc, a_bc, exp32_null, exp32_frames, exp32_bytes);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int acc_n, g0, refused;
        br = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            send32(32'h03020100 + 32'h04040404 * 32'(i) + 32'h50505050, 4'hF, i == 5, 3, acc);
            if (!acc) break;
            acc_n++;
        end
        checks++;
        if (acc_n !== 4) begin errors++; $display("FAIL stall_accepted: got %0d beats, required 4", acc_n); end
        checks++;
        if (a_tready !== 1'b0 || a_lvl !== 3'd4 || a_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_state: tready=%b level=%0d valid=%b, required tready=0 level=4 valid=1", a_tready, a_lvl, a_valid);
        end
        br = 1'b1;
        g0 = gaps;
        refused = 0;
        for (int i = acc_n; i < 6; i++) begin
            send32(32'h03020100 + 32'h04040404 * 32'(i) + 32'h50505050, 4'hF, i == 5, 16, acc);
            if (!acc) refused++;
        end
        checks++;
        if (refused != 0) begin errors++; $display("FAIL release_accept: refused=%0d, required 0", refused); end
        drain(60);
        checks++;
        if (gaps != g0) begin errors++; $display("FAIL release_gaps: got %0d gaps, required 0", gaps - g0); end
    endtask

    task automatic test_clear_same_cycle();
        bit acc;
        int n;
        br = 1'b1;
        send32(32'h87654321, 4'hF, 1'b1, 4, acc);
        n = 0;
        while (!a_valid && n < 8) begin step(); n++; end
        checks++;
        if (a_valid !== 1'b1) begin errors++; $display("FAIL clear_wait: valid=%b, required 1", a_valid); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (a_bc !== 32'd0 || a_fc !== 32'd0 || a_nc !== 32'd0) begin
            errors++;
            $display("FAIL clear_vs_handshake: bytes=%0d frames=%0d null=%0d, required 0", a_bc, a_fc, a_nc);
        end
        exp32_bytes = 3; exp32_frames = 1; exp32_null = 0;
        drain(20);
        checks++;
        if (a_bc !== 32'(exp32_bytes) || a_fc !== 32'(exp32_frames) || b_bc !== 32'(exp32_bytes) || b_nc !== 32'd0) begin
            errors++;
            $display("FAIL counts_after_clear: a=%0d/%0d b=%0d/%0d, required %0d/%0d null 0", a_bc, a_fc, b_bc, b_nc, exp32_bytes, exp32_frames);
        end
    endtask

    task automatic test_random64();
        bit acc;
        int nb, timeouts;
        logic [7:0] k;
        timeouts = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                k = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                send64({$urandom, $urandom}, k, b == nb - 1, 200, acc);
                if (!acc) timeouts++;
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        checks++;
        if (timeouts != 0) begin errors++; $display("FAIL random_accept: %0d beats refused, required 0", timeouts); end
        drain(20000);
        rand_ready = 1'b0;
        br = 1'b1;
        drain(50);
        checks++;
        if (c_bc !== 32'(exp64_bytes) || c_fc !== 32'(exp64_frames) || c_nc !== 32'(exp64_null)) begin
            errors++;
            $display("FAIL counts_random: %0d/%0d/%0d, required %0d/%0d/%0d", c_bc, c_fc, c_nc, exp64_bytes, exp64_frames, exp64_null);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        br = 1'b0;
        send32(32'hA3A2A1A0, 4'hF, 1'b0, 4, acc);
        send32(32'hB3B2B1B0, 4'hF, 1'b1, 4, acc);
        step();
        rst_n = 1'b0;
        t32_valid = 1'b0;
        q_a.delete(); q_b.delete(); q_c.delete();
        exp32_bytes = 0; exp32_frames = 0; exp32_null = 0;
        exp64_bytes = 0; exp64_frames = 0; exp64_null = 0;
        prev_av = 0; prev_bv = 0; prev_cv = 0;
        repeat (2) step();
        checks++;
        if (a_valid !== 1'b0 || a_lvl !== 3'd0 || b_lvl !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_state: valid=%b level=%0d/%0d, required 0", a_valid, a_lvl, b_lvl);
        end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (a_bc !== 32'd0 || a_fc !== 32'd0 || b_bc !== 32'd0 || c_bc !== 32'd0) begin
            errors++;
            $display("FAIL counters_after_reset: a=%0d/%0d b=%0d c=%0d, required 0", a_bc, a_fc, b_bc, c_bc);
        end
        br = 1'b1;
        send32(32'h0D0C0B0A, 4'hF, 1'b1, 4, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL accept_after_reset: got 0, required 1"); end
        drain(20);
        checks++;
        if (a_bc !== 32'd4 || a_fc !== 32'd1 || b_bc !== 32'd4 || b_fc !== 32'd1) begin
            errors++;
            $display("FAIL counts_clean_frame: a=%0d/%0d b=%0d/%0d, required 4/1", a_bc, a_fc, b_bc, b_fc);
        end
    endtask

    initial begin
        test_reset();
        test_full_keep();
        test_sparse();
        test_backpressure();
        test_clear_same_cycle();
        test_random64();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, required the run to complete");
        $fatal(1, "watchdog expired");
    end

endmodule
